// File: rtl/key_debounce.sv
// Multi-channel push-button debouncer sampled by a 1 kHz strobe; emits clean levels plus press/release pulses.
// Optional auto-repeat of key_press while held: define KEY_DEBOUNCE_AUTO_REPEAT_EN.
module key_debounce #(
  parameter int N_KEYS           = 4,
  parameter int STABLE_MS        = 20,
  parameter int ACTIVE_LOW       = 0,
  parameter int REPEAT_DELAY_MS  = 500,
  parameter int REPEAT_PERIOD_MS = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_1k,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

  localparam logic [9:0] STABLE   = 10'(STABLE_MS);
  localparam logic       INACTIVE = (ACTIVE_LOW != 0);

  logic [2:0]        ck_sync;
  logic              tick;
  logic [N_KEYS-1:0] k_meta;
  logic [N_KEYS-1:0] k_sync;
  logic [N_KEYS-1:0] raw;

  // NOTE: sequential state is written only with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, which is what makes the sync chains work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_sync <= '0;
      k_meta  <= {N_KEYS{INACTIVE}};
      k_sync  <= {N_KEYS{INACTIVE}};
    end else begin
      ck_sync <= {ck_sync[1:0], clk_1k};
      k_meta  <= key_in;
      k_sync  <= k_meta;
    end
  end

  assign tick = ck_sync[1] & ~ck_sync[2];
  assign raw  = k_sync ^ {N_KEYS{INACTIVE}};

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    state_t     state;
    logic [9:0] cnt;
    logic       level_q;
    logic       press_q;
    logic       release_q;
    logic       rpt_fire;

`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
    localparam logic [9:0] RPT_DELAY  = 10'(REPEAT_DELAY_MS);
    localparam logic [9:0] RPT_PERIOD = 10'(REPEAT_PERIOD_MS);

    logic [9:0] rpt;
    logic [9:0] rpt_next;
    logic       rpt_armed;

    assign rpt_next = rpt + 10'd1;
    assign rpt_fire = tick && (state == HELD) && raw[i] &&
                      (rpt_next == (rpt_armed ? RPT_PERIOD : RPT_DELAY));

    // Cleared while not yet accepted, so entry to HELD always starts at zero;
    // holds its value through REL_CHK so a glitchy release resumes the cadence.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rpt       <= '0;
        rpt_armed <= 1'b0;
      end else if (state == IDLE || state == PRESS_CHK) begin
        rpt       <= '0;
        rpt_armed <= 1'b0;
      end else if (tick && state == HELD && raw[i]) begin
        if (rpt_fire) begin
          rpt       <= '0;
          rpt_armed <= 1'b1;
        end else begin
          rpt <= rpt_next;
        end
      end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= IDLE;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (tick) begin
          case (state)
            IDLE: if (raw[i]) begin
              if (STABLE == 10'd1) begin
                state   <= HELD;
                level_q <= 1'b1;
                press_q <= 1'b1;
              end else begin
                state <= PRESS_CHK;
                cnt   <= 10'd1;
              end
            end
            PRESS_CHK: if (!raw[i]) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt + 10'd1 == STABLE) begin
              state   <= HELD;
              cnt     <= '0;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt <= cnt + 10'd1;
            end
            HELD: if (!raw[i]) begin
              if (STABLE == 10'd1) begin
                state     <= IDLE;
                level_q   <= 1'b0;
                release_q <= 1'b1;
              end else begin
                state <= REL_CHK;
                cnt   <= 10'd1;
              end
            end else begin
              press_q <= rpt_fire;
            end
            REL_CHK: if (raw[i]) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt + 10'd1 == STABLE) begin
              state     <= IDLE;
              cnt       <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt <= cnt + 10'd1;
            end
            default: begin
              state <= IDLE;
              cnt   <= '0;
            end
          endcase
        end
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: run-length debounce model checked every cycle, plus directed literal checks.
module tb_key_debounce;

  localparam int N      = 4;
  localparam int STABLE = 20;
  localparam int DELAY  = 50;
  localparam int PERIOD = 10;

  logic         clk    = 1'b0;
  logic         rst    = 1'b1;
  logic         clk_1k = 1'b0;
  logic [N-1:0] key_in = '1;
  logic [N-1:0] key_level, key_press, key_release;
  bit           run_1k = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int press_cnt [N];
  int rel_cnt   [N];
  int press_time[N];

  key_debounce #(
    .N_KEYS(N), .STABLE_MS(STABLE), .ACTIVE_LOW(0),
    .REPEAT_DELAY_MS(DELAY), .REPEAT_PERIOD_MS(PERIOD)
  ) dut (
    .clk(clk), .rst(rst), .clk_1k(clk_1k), .key_in(key_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release)
  );

  always #5 clk = ~clk;

  // 1 kHz stand-in: toggles every 5 clk, so one tick every 10 clk.
  initial forever begin
    repeat (5) @(posedge clk);
    #2;
    if (run_1k) clk_1k = ~clk_1k;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a level flips once STABLE consecutive 1 kHz samples disagree with it.
  // Sampling sees clk_1k and key_in two clk late; a tick is a rising edge in that delayed view.
  logic [2:0]   c_hist = '0;
  logic [N-1:0] k_hist0 = '0, k_hist1 = '0;
  logic [N-1:0] exp_level = '0, exp_press = '0, exp_release = '0;
  logic         m_tick;
  int           lvl [N];
  int           run [N];
  int           hold[N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c_hist = '0; k_hist0 = '0; k_hist1 = '0;
      exp_level = '0; exp_press = '0; exp_release = '0;
      for (int i = 0; i < N; i++) begin lvl[i] = 0; run[i] = 0; hold[i] = 0; end
    end else begin
      m_tick      = c_hist[1] & ~c_hist[2];
      exp_press   = '0;
      exp_release = '0;
      if (m_tick) begin
        for (int i = 0; i < N; i++) begin
          if (int'(k_hist1[i]) != lvl[i]) begin
            run[i]++;
            if (run[i] == STABLE) begin
              lvl[i] = 1 - lvl[i];
              run[i] = 0;
              hold[i] = 0;
              if (lvl[i] == 1) exp_press[i] = 1'b1;
              else             exp_release[i] = 1'b1;
            end
          end else begin
`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
            if (lvl[i] == 1 && run[i] == 0) begin
              hold[i]++;
              if (hold[i] == DELAY || (hold[i] > DELAY && (hold[i] - DELAY) % PERIOD == 0))
                exp_press[i] = 1'b1;
            end
`endif
            run[i] = 0;
          end
        end
      end
      for (int i = 0; i < N; i++) exp_level[i] = (lvl[i] == 1);
      c_hist  = {c_hist[1:0], clk_1k};
      k_hist1 = k_hist0;
      k_hist0 = key_in;
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    check("outputs_vs_model", {20'd0, key_level, key_press, key_release},
          {20'd0, exp_level, exp_press, exp_release});
    for (int i = 0; i < N; i++) begin
      if (key_press[i])   begin press_cnt[i]++; press_time[i] = cyc; end
      if (key_release[i]) rel_cnt[i]++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (10 * n) step();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin press_cnt[i] = 0; rel_cnt[i] = 0; press_time[i] = 0; end
  endtask

  initial begin
    clear_counts();
    // Reset with all keys down: nothing may come out while reset is held.
    repeat (3) step();
    check("reset_outputs", {20'd0, key_level, key_press, key_release}, 32'd0);
    rst = 1'b0;
    ticks(17);
    for (int i = 0; i < N; i++) check("reset_no_early_press", press_cnt[i], 0);
    ticks(5);
    for (int i = 0; i < N; i++) check("reset_first_press", press_cnt[i], 1);
    check("reset_level_all", {28'd0, key_level}, 32'hF);
    key_in = '0;
    ticks(25);
    for (int i = 0; i < N; i++) check("release_all", rel_cnt[i], 1);
    check("release_level", {28'd0, key_level}, 32'h0);

    // Clean press on key 0.
    clear_counts();
    key_in[0] = 1'b1;
    ticks(30);
    check("clean_press_cnt", press_cnt[0], 1);
    check("clean_level", {31'd0, key_level[0]}, 32'd1);
    key_in[0] = 1'b0;
    ticks(25);

    // Bounce on key 1: 5 high / 1 low, three times, then steady.
    clear_counts();
    repeat (3) begin
      key_in[1] = 1'b1; ticks(5);
      key_in[1] = 1'b0; ticks(1);
    end
    check("bounce_no_press", press_cnt[1], 0);
    key_in[1] = 1'b1;
    ticks(18);
    check("bounce_still_quiet", press_cnt[1], 0);
    ticks(4);
    check("bounce_one_press", press_cnt[1], 1);
    key_in[1] = 1'b0;
    ticks(25);

    // Glitchy release on key 2: 19 low ticks are not enough, 20 are.
    key_in[2] = 1'b1;
    ticks(25);
    clear_counts();
    key_in[2] = 1'b0; ticks(19);
    key_in[2] = 1'b1; ticks(3);
    check("glitch_no_release", rel_cnt[2], 0);
    check("glitch_level_held", {31'd0, key_level[2]}, 32'd1);
    key_in[2] = 1'b0;
    ticks(25);
    check("glitch_release", rel_cnt[2], 1);
    check("glitch_level_low", {31'd0, key_level[2]}, 32'd0);

    // Independent channels: presses three ticks (30 clk) apart.
    clear_counts();
    key_in[0] = 1'b1; ticks(3);
    key_in[3] = 1'b1; ticks(25);
    check("indep_press0", press_cnt[0], 1);
    check("indep_press3", press_cnt[3], 1);
    check("indep_spacing", press_time[3] - press_time[0], 30);
    key_in[0] = 1'b0; key_in[3] = 1'b0;
    ticks(25);

    // Reset while key 1 is mid-qualification restarts its count.
    key_in[1] = 1'b1;
    ticks(10);
    rst = 1'b1;
    #1;
    check("midrst_immediate", {20'd0, key_level, key_press, key_release}, 32'd0);
    repeat (3) step();
    rst = 1'b0;
    clear_counts();
    ticks(15);
    check("midrst_no_press", press_cnt[1], 0);
    ticks(8);
    check("midrst_press", press_cnt[1], 1);
    key_in[1] = 1'b0;
    ticks(25);

    // Stopped strobe freezes all state.
    clear_counts();
    run_1k = 1'b0;
    key_in[0] = 1'b1;
    ticks(30);
    check("freeze_no_press", press_cnt[0], 0);
    run_1k = 1'b1;
    ticks(25);
    check("freeze_resume_press", press_cnt[0], 1);
    key_in[0] = 1'b0;
    ticks(25);

    // Long hold: auto-repeat fires at ticks 20, 70, 80, 90, 100 when enabled.
    clear_counts();
    key_in[0] = 1'b1;
    ticks(95);
`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
    check("hold_press_95", press_cnt[0], 4);
`else
    check("hold_press_95", press_cnt[0], 1);
`endif
    ticks(10);
`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
    check("hold_press_105", press_cnt[0], 5);
`else
    check("hold_press_105", press_cnt[0], 1);
`endif
    key_in[0] = 1'b0;
    ticks(25);

    // Random key activity with occasional resets; the per-cycle compare does the checking.
    for (int c = 0; c < 12000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 59) == 0) key_in[i] = ~key_in[i];
      if ($urandom_range(0, 2999) == 0) rst = 1'b1;
      else                              rst = 1'b0;
      step();
    end
    rst = 1'b0;
    key_in = '0;
    ticks(25);
    check("final_idle_level", {28'd0, key_level}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
